// File: rtl/bufg_ce_ctrl.sv
// Sequencer for a shared gated global clock: qualifies PLL lock, arbitrates
// requesters, settles the BUFGCE enable before ack/reset release, idles it off.
module bufg_ce_ctrl #(
  parameter int N_REQ         = 4,
  parameter int LOCK_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int IDLE_CYCLES   = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             locked_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] ack_o,
  output logic             ce_o,
  output logic             domain_rst_no,
  output logic [2:0]       state_o,
  output logic [7:0]       lock_loss_cnt_o
);

  localparam int MAX_LS  = (LOCK_CYCLES > SETTLE_CYCLES) ? LOCK_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_LS > IDLE_CYCLES) ? MAX_LS : IDLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    OFF       = 3'd1,
    SETTLE    = 3'd2,
    ON        = 3'd3,
    IDLE      = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         loss_q, loss_d;
  logic [N_REQ-1:0]   ack_q;
  logic               ce_q;
  logic               drst_q;
  logic               anyReq;

  assign anyReq = |req_i;

  // One shared counter serves lock qualification, settling and idle timeout,
  // since only one of them is ever active in a given state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    if (state_q != WAIT_LOCK && !locked_i) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (!locked_i) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = OFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        OFF: begin
          if (anyReq) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST || !anyReq) begin
            state_d = ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ON: begin
          if (!anyReq) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        IDLE: begin
          // A request arriving on the timeout edge keeps the clock running.
          if (anyReq) begin
            state_d = ON;
            cnt_d   = '0;
          end else if (cnt_q == IDLE_LAST) begin
            state_d = OFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      loss_q  <= '0;
      ack_q   <= '0;
      ce_q    <= 1'b0;
      drst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      loss_q  <= loss_d;
      ce_q    <= (state_d == SETTLE) || (state_d == ON) || (state_d == IDLE);
      drst_q  <= (state_d == ON) || (state_d == IDLE);
      ack_q   <= (state_d == ON) ? req_i : '0;
    end
  end

  assign ack_o           = ack_q;
  assign ce_o            = ce_q;
  assign domain_rst_no   = drst_q;
  assign state_o         = state_q;
  assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_bufg_ce_ctrl.sv
// Scoreboard bench for bufg_ce_ctrl: a phase/countdown reference model queues
// the expected outputs per cycle and an independent monitor compares them.
module tb_bufg_ce_ctrl;

  localparam int N_REQ         = 4;
  localparam int LOCK_CYCLES   = 16;
  localparam int SETTLE_CYCLES = 4;
  localparam int IDLE_CYCLES   = 64;

  typedef struct packed {
    logic             ce;
    logic             drst;
    logic [N_REQ-1:0] ack;
    logic [2:0]       st;
    logic [7:0]       loss;
  } expT;

  logic             clock = 1'b0;
  logic             rstN = 1'b0;
  logic             locked = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic [N_REQ-1:0] ackO;
  logic             ceO;
  logic             drstNO;
  logic [2:0]       stateO;
  logic [7:0]       lossO;

  expT expQ[$];
  int  checks = 0;
  int  failures = 0;

  // Reference model: phase numbers follow the documented state encoding,
  // timers count down the number of cycles remaining in a phase.
  int mPhase = 0;
  int mLockRun = 0;
  int mSettleLeft = 0;
  int mIdleLeft = 0;
  int mLoss = 0;

  always #5 clock = ~clock;

  bufg_ce_ctrl #(
    .N_REQ(N_REQ), .LOCK_CYCLES(LOCK_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES), .IDLE_CYCLES(IDLE_CYCLES)
  ) dut (
    .clk_i(clock), .rst_ni(rstN), .locked_i(locked), .req_i(req),
    .ack_o(ackO), .ce_o(ceO), .domain_rst_no(drstNO),
    .state_o(stateO), .lock_loss_cnt_o(lossO)
  );

  task automatic modelStep(input logic r, input logic l, input logic [N_REQ-1:0] q);
    expT e;
    if (!r) begin
      mPhase = 0; mLockRun = 0; mLoss = 0;
    end else if (mPhase != 0 && !l) begin
      mPhase = 0; mLockRun = 0;
      mLoss = (mLoss >= 255) ? 255 : mLoss + 1;
    end else begin
      case (mPhase)
        0: begin
          if (l) begin
            mLockRun++;
            if (mLockRun == LOCK_CYCLES) begin mPhase = 1; mLockRun = 0; end
          end else mLockRun = 0;
        end
        1: if (q != 0) begin mPhase = 2; mSettleLeft = SETTLE_CYCLES; end
        2: begin
          mSettleLeft--;
          if (mSettleLeft == 0 || q == 0) mPhase = 3;
        end
        3: if (q == 0) begin mPhase = 4; mIdleLeft = IDLE_CYCLES; end
        4: begin
          if (q != 0) mPhase = 3;
          else begin
            mIdleLeft--;
            if (mIdleLeft == 0) mPhase = 1;
          end
        end
        default: mPhase = 0;
      endcase
    end
    e.ce   = (mPhase >= 2);
    e.drst = (mPhase == 3 || mPhase == 4);
    e.ack  = (mPhase == 3) ? q : '0;
    e.st   = 3'(mPhase);
    e.loss = 8'(mLoss);
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic r, input logic l, input logic [N_REQ-1:0] q);
    @(negedge clock);
    rstN = r; locked = l; req = q;
    modelStep(r, l, q);
  endtask

  task automatic runCycles(input int n, input logic r, input logic l, input logic [N_REQ-1:0] q);
    for (int i = 0; i < n; i++) applyStimulus(r, l, q);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  // Monitor: the DUT presents a registered output every cycle.
  initial begin
    expT e;
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("ce_o", int'(ceO), int'(e.ce));
        checkOutput("domain_rst_no", int'(drstNO), int'(e.drst));
        checkOutput("ack_o", int'(ackO), int'(e.ack));
        checkOutput("state_o", int'(stateO), int'(e.st));
        checkOutput("lock_loss_cnt_o", int'(lossO), int'(e.loss));
        if (ackO != '0) checkOutput("ackWithoutCe", int'(ceO), 1);
      end
    end
  end

  initial begin
    logic [N_REQ-1:0] rq;
    logic             rr;
    logic             rl;

    $display("[TB] reset");
    runCycles(3, 1'b0, 1'b0, 4'b0000);

    $display("[TB] lock qualification");
    runCycles(10, 1'b1, 1'b1, 4'b0000);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    runCycles(16, 1'b1, 1'b1, 4'b0000);
    runCycles(3, 1'b1, 1'b1, 4'b0000);

    $display("[TB] turn-on and multi-requester");
    runCycles(8, 1'b1, 1'b1, 4'b0001);
    runCycles(5, 1'b1, 1'b1, 4'b0101);
    runCycles(3, 1'b1, 1'b1, 4'b0100);

    $display("[TB] idle timeout");
    runCycles(70, 1'b1, 1'b1, 4'b0000);
    runCycles(8, 1'b1, 1'b1, 4'b0001);
    runCycles(IDLE_CYCLES, 1'b1, 1'b1, 4'b0000);
    runCycles(4, 1'b1, 1'b1, 4'b0010);

    $display("[TB] early drop during settle");
    runCycles(IDLE_CYCLES + 2, 1'b1, 1'b1, 4'b0000);
    runCycles(2, 1'b1, 1'b1, 4'b1000);
    runCycles(4, 1'b1, 1'b1, 4'b0000);

    $display("[TB] lock loss and saturation");
    runCycles(10, 1'b1, 1'b1, 4'b0011);
    applyStimulus(1'b1, 1'b0, 4'b0011);
    for (int i = 0; i < 300; i++) begin
      runCycles(LOCK_CYCLES, 1'b1, 1'b1, 4'b0000);
      applyStimulus(1'b1, 1'b0, 4'b0000);
    end

    $display("[TB] reset during settle");
    runCycles(LOCK_CYCLES, 1'b1, 1'b1, 4'b0000);
    runCycles(2, 1'b1, 1'b1, 4'b0001);
    applyStimulus(1'b0, 1'b1, 4'b0001);
    runCycles(2, 1'b1, 1'b1, 4'b0001);

    $display("[TB] randomized traffic");
    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 299) != 0);
      rl = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 29) == 0)
        rq = ($urandom_range(0, 1) == 1) ? '0 : N_REQ'($urandom_range(0, 15));
      applyStimulus(rr, rl, rq);
    end

    @(posedge clock);
    #3;
    checkOutput("queueDrained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
